// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard scoreboard and its operand matcher.
package hazard_scoreboard_pkg;

    // Decoder opcode encoding shared with the decode stage.
    typedef enum logic [2:0] {
        ARITHM = 3'd0,
        LW     = 3'd1,
        SW     = 3'd2,
        BE     = 3'd3,
        BLT    = 3'd4,
        BGT    = 3'd5,
        NOP    = 3'd6
    } opcode_t;

    // Destination field is sized for the largest supported register file;
    // narrower register indices are zero-extended before being stored or compared.
    localparam int HZ_DEST_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [HZ_DEST_W-1:0] dest;
        logic                 is_load;
    } hz_entry_t;

    localparam hz_entry_t HZ_ENTRY_EMPTY = '{valid: 1'b0, dest: 8'd0, is_load: 1'b0};

    // Bit positions inside the haz output.
    localparam int HAZ_LOAD_USE = 0;
    localparam int HAZ_BRANCH   = 1;
    localparam int HAZ_R0       = 2;
    localparam int HAZ_FWD      = 3;

endpackage

// File: rtl/hazard_scoreboard_fwd_match.sv
// Compares one read operand against every tracked entry and returns the
// youngest matching stage (0 = no match, register file) plus its load flag.
module hazard_fwd_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = 2
) (
    input  hz_entry_t            entries [FWD_DEPTH],
    input  logic [HZ_DEST_W-1:0] operand,
    output logic [SEL_W-1:0]     sel,
    output logic                 is_load
);

    logic hit_s;

    // Walk oldest to youngest so the youngest matching stage wins.
    always_comb begin
        sel     = {SEL_W{1'b0}};
        is_load = 1'b0;
        hit_s   = 1'b0;
        for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
            hit_s   = entries[i].valid && (entries[i].dest == operand);
            sel     = hit_s ? SEL_W'(i + 1) : sel;
            is_load = hit_s ? entries[i].is_load : is_load;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode/issue hazard scoreboard: tracks in-flight destinations, selects
// forwarding sources and raises load-use, branch-data and busy-R0 stalls.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int FWD_DEPTH  = 2,
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             issue_valid,
    input  opcode_t                          issue_opcode,
    input  logic                             issue_r0_en,
    input  logic [$clog2(NUM_REGS)-1:0]      issue_r1,
    input  logic [$clog2(NUM_REGS)-1:0]      issue_r2,
    input  logic                             flush,
    output logic                             issue_ready,
    output logic                             stall,
    output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_r1,
    output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_r2,
    output logic [3:0]                       haz,
    output logic [CNT_W-1:0]                 stall_count
);

    localparam int SEL_W = $clog2(FWD_DEPTH + 1);
    localparam logic [SEL_W-1:0] STAGE1 = SEL_W'(1);

    hz_entry_t             entries_r [FWD_DEPTH];
    logic [3:0]            r0_cnt_r;
    logic [CNT_W-1:0]      stall_cnt_r;

    logic                  rd_r1_s, rd_r2_s, wr_r1_s, is_branch_s, is_load_s;
    logic [HZ_DEST_W-1:0]  op1_s, op2_s;
    logic [SEL_W-1:0]      sel_r1_s, sel_r2_s;
    logic                  ld_r1_s, ld_r2_s;
    logic                  use_r1_s, use_r2_s;
    logic                  load_use_s, branch_s, r0_haz_s, stall_s, accept_s;
    logic [SEL_W-1:0]      fwd_r1_s, fwd_r2_s;
    hz_entry_t             new_entry_s;

    assign op1_s = HZ_DEST_W'(issue_r1);
    assign op2_s = HZ_DEST_W'(issue_r2);

    // Decode which fields the presented instruction reads and writes.
    always_comb begin
        rd_r1_s     = 1'b0;
        rd_r2_s     = 1'b0;
        wr_r1_s     = 1'b0;
        is_branch_s = 1'b0;
        is_load_s   = 1'b0;
        if (issue_r0_en) begin
            rd_r1_s = 1'b1;
            rd_r2_s = 1'b1;
        end else begin
            case (issue_opcode)
                ARITHM: begin
                    rd_r1_s = 1'b1;
                    rd_r2_s = 1'b1;
                    wr_r1_s = 1'b1;
                end
                LW: begin
                    rd_r2_s   = 1'b1;
                    wr_r1_s   = 1'b1;
                    is_load_s = 1'b1;
                end
                SW: begin
                    rd_r1_s = 1'b1;
                    rd_r2_s = 1'b1;
                end
                BE, BLT, BGT: begin
                    rd_r1_s     = 1'b1;
                    is_branch_s = 1'b1;
                end
                default: begin
                    rd_r1_s = 1'b0;
                end
            endcase
        end
    end

    hazard_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_match_r1 (
        .entries (entries_r),
        .operand (op1_s),
        .sel     (sel_r1_s),
        .is_load (ld_r1_s)
    );

    hazard_fwd_match #(.FWD_DEPTH(FWD_DEPTH), .SEL_W(SEL_W)) u_match_r2 (
        .entries (entries_r),
        .operand (op2_s),
        .sel     (sel_r2_s),
        .is_load (ld_r2_s)
    );

    // Hazard detection; forwarding is suppressed while the instruction is held.
    always_comb begin
        use_r1_s   = issue_valid & rd_r1_s;
        use_r2_s   = issue_valid & rd_r2_s;
        load_use_s = (use_r1_s & (sel_r1_s == STAGE1) & ld_r1_s) |
                     (use_r2_s & (sel_r2_s == STAGE1) & ld_r2_s);
        branch_s   = use_r1_s & is_branch_s & (sel_r1_s == STAGE1);
        r0_haz_s   = issue_valid & (r0_cnt_r != 4'd0) & (is_branch_s | issue_r0_en);
        stall_s    = load_use_s | branch_s | r0_haz_s;
        fwd_r1_s   = (use_r1_s & ~stall_s) ? sel_r1_s : {SEL_W{1'b0}};
        fwd_r2_s   = (use_r2_s & ~stall_s) ? sel_r2_s : {SEL_W{1'b0}};
        accept_s   = issue_valid & ~stall_s & ~flush;
        new_entry_s         = HZ_ENTRY_EMPTY;
        new_entry_s.valid   = accept_s & wr_r1_s;
        new_entry_s.dest    = op1_s;
        new_entry_s.is_load = is_load_s;
    end

    assign stall       = stall_s;
    assign issue_ready = ~stall_s;
    assign fwd_r1      = fwd_r1_s;
    assign fwd_r2      = fwd_r2_s;
    assign stall_count = stall_cnt_r;

    always_comb begin
        haz               = 4'b0000;
        haz[HAZ_LOAD_USE] = load_use_s;
        haz[HAZ_BRANCH]   = branch_s;
        haz[HAZ_R0]       = r0_haz_s;
        haz[HAZ_FWD]      = issue_valid & ((fwd_r1_s != {SEL_W{1'b0}}) | (fwd_r2_s != {SEL_W{1'b0}}));
    end

    // Shift the scoreboard each cycle; flush kills every tracked entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FWD_DEPTH; i++) entries_r[i] <= HZ_ENTRY_EMPTY;
        end else if (flush) begin
            for (int i = 0; i < FWD_DEPTH; i++) entries_r[i] <= HZ_ENTRY_EMPTY;
        end else begin
            for (int i = 1; i < FWD_DEPTH; i++) entries_r[i] <= entries_r[i-1];
            entries_r[0] <= new_entry_s;
        end
    end

    // R0 busy counter: reload on an accepted MULT/DIV, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_cnt_r <= 4'd0;
        end else if (accept_s && issue_r0_en) begin
            r0_cnt_r <= 4'(MULDIV_LAT);
        end else if (r0_cnt_r != 4'd0) begin
            r0_cnt_r <= r0_cnt_r - 4'd1;
        end else begin
            r0_cnt_r <= r0_cnt_r;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a depth-2 and a depth-3 instance share stimulus.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    opcode_t    issue_opcode;
    logic       issue_r0_en;
    logic [3:0] issue_r1, issue_r2;
    logic       flush;

    logic        ready2, stall2, ready3, stall3;
    logic [1:0]  fwd1_2, fwd2_2, fwd1_3, fwd2_3;
    logic [3:0]  haz2, haz3;
    logic [15:0] cnt2, cnt3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NUM_REGS(16), .FWD_DEPTH(2), .MULDIV_LAT(4), .CNT_W(16)) d2 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_r0_en(issue_r0_en), .issue_r1(issue_r1), .issue_r2(issue_r2), .flush(flush),
        .issue_ready(ready2), .stall(stall2), .fwd_r1(fwd1_2), .fwd_r2(fwd2_2),
        .haz(haz2), .stall_count(cnt2)
    );

    hazard_scoreboard #(.NUM_REGS(16), .FWD_DEPTH(3), .MULDIV_LAT(4), .CNT_W(16)) d3 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
        .issue_r0_en(issue_r0_en), .issue_r1(issue_r1), .issue_r2(issue_r2), .flush(flush),
        .issue_ready(ready3), .stall(stall3), .fwd_r1(fwd1_3), .fwd_r2(fwd2_3),
        .haz(haz3), .stall_count(cnt3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one instruction at the falling edge and let it settle before checks.
    task automatic present(input logic v, input opcode_t op, input logic r0,
                           input logic [3:0] a, input logic [3:0] b, input logic fl);
        @(negedge clk);
        issue_valid  = v;
        issue_opcode = op;
        issue_r0_en  = r0;
        issue_r1     = a;
        issue_r2     = b;
        flush        = fl;
        #2;
    endtask

    task automatic bubble();
        present(1'b0, NOP, 1'b0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; issue_valid = 1'b0; issue_opcode = NOP; issue_r0_en = 1'b0;
        issue_r1 = 4'd0; issue_r2 = 4'd0; flush = 1'b0;
        @(negedge clk); @(negedge clk); #2;
        check("rst_stall", stall2, 1'b0);
        check("rst_ready", ready2, 1'b1);
        check("rst_fwd", {fwd1_2, fwd2_2}, 4'd0);
        check("rst_haz", haz2, 4'd0);
        check("rst_cnt", cnt2, 16'd0);
        @(negedge clk); rst_n = 1'b1;

        // Load-use: LW r3, then ARITHM r5,r3
        present(1'b1, LW, 1'b0, 4'd3, 4'd0, 1'b0);
        check("lw_nostall", stall2, 1'b0);
        present(1'b1, ARITHM, 1'b0, 4'd5, 4'd3, 1'b0);
        check("lu_stall", stall2, 1'b1);
        check("lu_ready", ready2, 1'b0);
        check("lu_haz", haz2, 4'b0001);
        present(1'b1, ARITHM, 1'b0, 4'd5, 4'd3, 1'b0);
        check("lu_after_stall", stall2, 1'b0);
        check("lu_fwd_r2", fwd2_2, 2'd2);
        check("lu_after_haz", haz2, 4'b1000);
        check("lu_cnt", cnt2, 16'd1);

        // Back-to-back ARITHM forwarding from stage 1
        present(1'b1, ARITHM, 1'b0, 4'd4, 4'd9, 1'b0);
        check("ar_first_haz", haz2, 4'b0000);
        present(1'b1, ARITHM, 1'b0, 4'd4, 4'd4, 1'b0);
        check("ar_fwd_r1", fwd1_2, 2'd1);
        check("ar_fwd_r2", fwd2_2, 2'd1);
        check("ar_haz", haz2, 4'b1000);
        check("ar_stall", stall2, 1'b0);
        present(1'b0, ARITHM, 1'b0, 4'd4, 4'd4, 1'b0);
        check("novalid_fwd", {fwd1_2, fwd2_2}, 4'd0);
        check("novalid_haz", haz2, 4'd0);
        bubble();

        // MULT then BE: four R0 stall cycles
        present(1'b1, ARITHM, 1'b1, 4'd1, 4'd2, 1'b0);
        check("mult_stall", stall2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            present(1'b1, BE, 1'b0, 4'd1, 4'd0, 1'b0);
            check($sformatf("r0_stall_%0d", i), stall2, 1'b1);
            check($sformatf("r0_haz_%0d", i), haz2, 4'b0100);
        end
        present(1'b1, BE, 1'b0, 4'd1, 4'd0, 1'b0);
        check("r0_release", stall2, 1'b0);
        check("r0_cnt", cnt2, 16'd5);

        // Branch on stage-1 data, then forward from stage 2
        present(1'b1, ARITHM, 1'b0, 4'd6, 4'd0, 1'b0);
        present(1'b1, BE, 1'b0, 4'd6, 4'd0, 1'b0);
        check("br_stall", stall2, 1'b1);
        check("br_haz", haz2, 4'b0010);
        present(1'b1, BE, 1'b0, 4'd6, 4'd0, 1'b0);
        check("br_release", stall2, 1'b0);
        check("br_fwd_r1", fwd1_2, 2'd2);
        check("br_fwd_haz", haz2, 4'b1000);
        check("br_cnt", cnt2, 16'd6);

        // Flush kills tracked entries and drops the same-cycle issue
        present(1'b1, ARITHM, 1'b0, 4'd7, 4'd0, 1'b0);
        present(1'b1, ARITHM, 1'b0, 4'd9, 4'd0, 1'b1);
        present(1'b1, SW, 1'b0, 4'd7, 4'd9, 1'b0);
        check("fl_fwd_r1", fwd1_2, 2'd0);
        check("fl_fwd_r2", fwd2_2, 2'd0);
        check("fl_stall", stall2, 1'b0);
        check("fl_cnt", cnt2, 16'd6);

        // Depth-3 forwarding from the oldest stage, then retirement
        bubble(); bubble(); bubble();
        present(1'b1, ARITHM, 1'b0, 4'd2, 4'd11, 1'b0);
        bubble(); bubble();
        present(1'b1, SW, 1'b0, 4'd2, 4'd12, 1'b0);
        check("d3_fwd_r1", fwd1_3, 2'd3);
        check("d3_haz", haz3, 4'b1000);
        check("d2_retired", fwd1_2, 2'd0);
        present(1'b1, SW, 1'b0, 4'd2, 4'd12, 1'b0);
        check("d3_retired", fwd1_3, 2'd0);

        // Reset pulsed during a MULT-induced stall
        present(1'b1, ARITHM, 1'b0, 4'd1, 4'd5, 1'b0);
        present(1'b1, ARITHM, 1'b1, 4'd3, 4'd4, 1'b0);
        present(1'b1, BE, 1'b0, 4'd1, 4'd0, 1'b0);
        check("pre_rst_stall", stall2, 1'b1);
        check("pre_rst_haz", haz2, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", stall2, 1'b0);
        check("mid_rst_ready", ready2, 1'b1);
        check("mid_rst_cnt", cnt2, 16'd0);
        check("mid_rst_fwd", fwd1_2, 2'd0);
        check("mid_rst_fwd_d3", fwd1_3, 2'd0);
        check("mid_rst_stall_d3", stall3, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        #2;
        check("post_rst_stall", stall2, 1'b0);
        check("post_rst_haz", haz2, 4'd0);
        check("post_rst_cnt", cnt2, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the combinational hazard detector. It tracks the destination register of every in-flight instruction in a shift scoreboard and produces per-operand forwarding selects. It also generates stalls for load-use, branch-on-fresh-data and busy multi-cycle MULT/DIV (implicit R0). The block sits at decode/issue, between the instruction decoder and the register-file/ALU operand muxes.

## Interface
Parameters:
- NUM_REGS, 16, architectural register count; register index width RW = $clog2(NUM_REGS)
- FWD_DEPTH, 2, number of tracked in-flight stages; legal range 1..7
- MULDIV_LAT, 4, cycles until a MULT/DIV result in R0 is forwardable; legal range 1..15
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decoder presents an instruction
- issue_opcode  in  opcode_t  opcode of the presented instruction
- issue_r0_en  in  1  instruction is MULT/DIV and writes R0
- issue_r1  in  RW  first register field
- issue_r2  in  RW  second register field
- flush  in  1  branch taken; kill all tracked entries
- issue_ready  out  1  equals !stall
- stall  out  1  hold the decode stage this cycle
- fwd_r1  out  $clog2(FWD_DEPTH+1)  0 = register file; k = stage k (1 = youngest)
- fwd_r2  out  $clog2(FWD_DEPTH+1)  same encoding for r2
- haz  out  4  [0] load-use, [1] branch data, [2] R0 busy, [3] any forward active; flags are not one-hot
- stall_count  out  CNT_W  saturating count of stall cycles

## Operation
- Read/write rules:
  - ARITHM reads r1 and r2, writes r1.
  - LW reads r2, writes r1.
  - SW reads r1 and r2, writes nothing.
  - BE, BLT and BGT read r1 and R0, write nothing.
  - Any opcode with issue_r0_en reads r1 and r2, writes R0 only.
- Scoreboard: FWD_DEPTH entries, each {valid, dest[RW], is_load}.
  - Every cycle the scoreboard shifts by one.
  - Stage 1 loads the accepted instruction if it writes r1; otherwise it loads a bubble (valid = 0).
  - A stalled or invalid issue loads a bubble.
- Forwarding: for each read operand, fwd_* selects the youngest valid entry with dest == operand; otherwise it selects 0. Index 0 compares normally.
- Load-use stall (haz[0]): a source matches stage 1 and that entry is_load.
- Branch stall (haz[1]): branch r1 matches a valid entry in stage 1. The branch compares in decode, so stage-1 data is too late.
- R0 counter: r0_busy is a 4-bit down-counter.
  - An accepted issue_r0_en op loads MULDIV_LAT.
  - Otherwise the counter decrements while nonzero.
  - haz[2] is set when the counter is nonzero and the presented instruction is a branch or issue_r0_en.
- stall = issue_valid & (haz[0] | haz[1] | haz[2]).
- haz[3] = any fwd_* nonzero while issue_valid.
- stall_count increments on every stall cycle and saturates at all-ones.
- Flush:
  - Clears all entry valid bits on the next edge; the issue in the same cycle is dropped.
  - Does not clear the R0 counter, because the MULT/DIV unit completes regardless.
  - Does not clear stall_count.

## Timing
- Reset values: all entries invalid, R0 counter 0, stall_count 0. With issue_valid low, stall = 0, fwd_r1 = fwd_r2 = 0, haz = 0 and issue_ready = 1.
- All outputs except stall_count are combinational from the issue inputs and registered state, and are valid in the same cycle. stall_count is registered and updates one cycle after the stall.
- Load-use costs exactly 1 stall cycle. The following cycle forwards from stage 2.
- Branch after ARITHM or LW costs 1 stall cycle; the stage-2 match is then forwarded.
- A branch immediately after MULT/DIV stalls MULDIV_LAT cycles; a branch issued k cycles later stalls max(0, MULDIV_LAT-k).
- MULT/DIV followed by MULT/DIV: the second stalls until the counter reaches 0, then reloads it.
- Reset asserted mid-stall clears all state asynchronously. stall drops immediately if the counter was the only cause.
- Entries older than FWD_DEPTH retire, and operands are then read from the register file.

## Structure
- types_pkg gains the constants and one typedef:
  - hz_entry_t {valid, dest, is_load}
  - HAZ_LOAD_USE = 0, HAZ_BRANCH = 1, HAZ_R0 = 2, HAZ_FWD = 3
- opcode_t is reused unchanged.
- Sub-module hazard_fwd_match: one read operand against the entry array, returns the youngest-match select and the is_load of that match. It is instantiated twice (r1, r2).

## Test plan
- LW r3 then ARITHM r5,r3 back-to-back → stall = 1, haz = 4'b0001 for 1 cycle; next cycle fwd_r2 = 2, stall = 0.
- ARITHM r4 then ARITHM r4,r4 → no stall, fwd_r1 = fwd_r2 = 1, haz = 4'b1000.
- MULT (MULDIV_LAT = 4) then BE r1 → stall held 4 cycles, stall_count = 4, then branch accepted.
- ARITHM r7, then flush, then SW r7 → fwd_r1 = 0, no forward and no stall.
- FWD_DEPTH = 3, ARITHM r2 followed by 2 bubbles then SW r2 → fwd_r1 = 3. After one more bubble → fwd_r1 = 0.
- rst_n pulsed low during a MULT-induced stall → stall = 0 and stall_count = 0 immediately, and all entries are invalid.
